// File: rtl/ldst_pkg.sv
// Shared types and constants for the LDUR/STUR memory-stage sequencer.
// Holds the FSM state encoding, alignment width and timeout defaults.
package ldst_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int ALIGN_BITS      = 3;
  localparam int TIMEOUT_DEFAULT = 16;
  localparam int CNT_W_DEFAULT   = $clog2(TIMEOUT_DEFAULT);

endpackage

// File: rtl/dAddr9Extend.sv
// Sign-extends the 9-bit D-type byte offset to the datapath width.
// Ports: dAddr9 (signed offset in), ext (sign-extended offset out).
module dAddr9Extend #(
  parameter int W = 64
) (
  input  logic [8:0]   dAddr9,
  output logic [W-1:0] ext
);

  assign ext = {{(W-9){dAddr9[8]}}, dAddr9};

endmodule

// File: rtl/ldst_mem_sequencer.sv
// Memory-stage controller for LDUR/STUR: forms ea, checks alignment,
// runs req/ack with a variable-latency data memory and stalls the pipe.
// Ports: op_* / base_addr / dAddr9 / store_data / dest_reg from EX/MEM;
// mem_* to/from data memory; stall to the pipe; ld_* to MEM/WB;
// align_fault / timeout_fault one-cycle fault pulses.
module ldst_mem_sequencer
  import ldst_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic              op_is_load,
  input  logic              op_is_store,
  input  logic [DATA_W-1:0] base_addr,
  input  logic [8:0]        dAddr9,
  input  logic [DATA_W-1:0] store_data,
  input  logic [4:0]        dest_reg,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              ld_valid,
  output logic [DATA_W-1:0] ld_data,
  output logic [4:0]        ld_reg,
  output logic              align_fault,
  output logic              timeout_fault
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              req_q;
  logic              we_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [4:0]        dst_q;
  logic              ldv_q;
  logic [DATA_W-1:0] ldd_q;
  logic [4:0]        ldr_q;
  logic              afault_q;
  logic              tfault_q;

  logic [DATA_W-1:0] off_ext;
  logic [DATA_W-1:0] ea;
  logic              accept;
  logic              misalign;

  dAddr9Extend #(
    .W(DATA_W)
  ) u_ext (
    .dAddr9(dAddr9),
    .ext   (off_ext)
  );

  assign ea       = base_addr + off_ext;
  assign misalign = |ea[ALIGN_BITS-1:0];
  assign accept   = (state_q == IDLE) && op_valid
                    && (op_is_load || op_is_store);

  // Stall covers the accept cycle combinationally so EX/MEM
  // holds the op; reset gates it so it drops without a clock.
  assign stall = !reset
                 && ((accept && !misalign) || (state_q == BUSY));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      dst_q    <= '0;
      ldv_q    <= 1'b0;
      ldd_q    <= '0;
      ldr_q    <= '0;
      afault_q <= 1'b0;
      tfault_q <= 1'b0;
    end else begin
      ldv_q    <= 1'b0;
      afault_q <= 1'b0;
      tfault_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (misalign) begin
              afault_q <= 1'b1;
            end else begin
              addr_q  <= ea;
              wdata_q <= store_data;
              dst_q   <= dest_reg;
              // Load wins when both op flags are set.
              we_q    <= op_is_store && !op_is_load;
              cnt_q   <= '0;
              req_q   <= 1'b1;
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            req_q   <= 1'b0;
            state_q <= DONE;
            if (!we_q) begin
              ldd_q <= mem_rdata;
              ldr_q <= dst_q;
              ldv_q <= 1'b1;
            end
          end else if (cnt_q == CNT_MAX) begin
            req_q    <= 1'b0;
            tfault_q <= 1'b1;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req       = req_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign ld_valid      = ldv_q;
  assign ld_data       = ldd_q;
  assign ld_reg        = ldr_q;
  assign align_fault   = afault_q;
  assign timeout_fault = tfault_q;

endmodule

// File: tb/tb_ldst_mem_sequencer.sv
// Directed self-checking bench for ldst_mem_sequencer.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_ldst_mem_sequencer;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic        op_is_load;
  logic        op_is_store;
  logic [63:0] base_addr;
  logic [8:0]  dAddr9;
  logic [63:0] store_data;
  logic [4:0]  dest_reg;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        stall;
  logic        ld_valid;
  logic [63:0] ld_data;
  logic [4:0]  ld_reg;
  logic        align_fault;
  logic        timeout_fault;

  int passed = 0;
  int total  = 0;

  ldst_mem_sequencer #(
    .DATA_W (64),
    .TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .op_valid     (op_valid),
    .op_is_load   (op_is_load),
    .op_is_store  (op_is_store),
    .base_addr    (base_addr),
    .dAddr9       (dAddr9),
    .store_data   (store_data),
    .dest_reg     (dest_reg),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .stall        (stall),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_reg       (ld_reg),
    .align_fault  (align_fault),
    .timeout_fault(timeout_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic ld, input logic st,
                          input logic [63:0] b, input logic [8:0] o,
                          input logic [63:0] sd, input logic [4:0] rd);
    op_valid    = 1'b1;
    op_is_load  = ld;
    op_is_store = st;
    base_addr   = b;
    dAddr9      = o;
    store_data  = sd;
    dest_reg    = rd;
  endtask

  task automatic clear_op();
    op_valid    = 1'b0;
    op_is_load  = 1'b0;
    op_is_store = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({mem_req, stall, ld_valid, align_fault, timeout_fault} !== 5'b0)
      $display("FAIL reset_ctl: got %b want 00000",
               {mem_req, stall, ld_valid, align_fault, timeout_fault});
    else passed++;
    total++;
    if ({mem_addr, mem_wdata, ld_data} !== 192'b0)
      $display("FAIL reset_data: got %h %h %h want 0",
               mem_addr, mem_wdata, ld_data);
    else passed++;
    total++;
    if ({ld_reg, mem_we} !== 6'b0)
      $display("FAIL reset_reg: got %b want 0", {ld_reg, mem_we});
    else passed++;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_aligned_load();
    int st_cnt = 0;
    tick();
    drive_op(1'b1, 1'b0, 64'h1000, 9'h1F8, 64'h0, 5'd5);
    @(negedge clk);
    if (stall) st_cnt++;
    total++;
    if (mem_req !== 1'b0)
      $display("FAIL load_acc_req: got %b want 0", mem_req);
    else passed++;
    tick();
    clear_op();
    mem_ack   = 1'b1;
    mem_rdata = 64'hDEADBEEF;
    @(negedge clk);
    if (stall) st_cnt++;
    total++;
    if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 64'hFF8)
      $display("FAIL load_busy: got req/we %b addr %h want 10 ff8",
               {mem_req, mem_we}, mem_addr);
    else passed++;
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    if (stall) st_cnt++;
    total++;
    if (ld_valid !== 1'b1 || ld_data !== 64'hDEADBEEF || ld_reg !== 5'd5)
      $display("FAIL load_done: got v%b %h r%0d want v1 deadbeef r5",
               ld_valid, ld_data, ld_reg);
    else passed++;
    tick();
    @(negedge clk);
    total++;
    if (ld_valid !== 1'b0 || ld_data !== 64'hDEADBEEF)
      $display("FAIL load_hold: got v%b %h want v0 deadbeef",
               ld_valid, ld_data);
    else passed++;
    total++;
    if (st_cnt != 2)
      $display("FAIL load_stall_len: got %0d want 2", st_cnt);
    else passed++;
  endtask

  task automatic test_store();
    int st_cnt = 0;
    int bad    = 0;
    tick();
    drive_op(1'b0, 1'b1, 64'h2000, 9'h010, 64'h55, 5'd9);
    @(negedge clk);
    if (stall) st_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      clear_op();
      mem_ack = (i == 2);
      @(negedge clk);
      if (stall) st_cnt++;
      if (!mem_req || !mem_we || mem_addr !== 64'h2010
          || mem_wdata !== 64'h55)
        bad++;
    end
    total++;
    if (bad != 0)
      $display("FAIL store_busy: got %0d bad cycles want 0", bad);
    else passed++;
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    if (stall) st_cnt++;
    total++;
    if (ld_valid !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL store_done: got v%b req%b want 0 0",
               ld_valid, mem_req);
    else passed++;
    total++;
    if (ld_data !== 64'hDEADBEEF)
      $display("FAIL store_ld_hold: got %h want deadbeef", ld_data);
    else passed++;
    total++;
    if (st_cnt != 4)
      $display("FAIL store_stall_len: got %0d want 4", st_cnt);
    else passed++;
  endtask

  task automatic test_misaligned();
    tick();
    drive_op(1'b1, 1'b0, 64'h1003, 9'h000, 64'h0, 5'd1);
    @(negedge clk);
    total++;
    if (stall !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL mis_acc: got stall%b req%b want 0 0",
               stall, mem_req);
    else passed++;
    tick();
    clear_op();
    @(negedge clk);
    total++;
    if (align_fault !== 1'b1 || mem_req !== 1'b0 || stall !== 1'b0)
      $display("FAIL mis_fault: got af%b req%b st%b want 1 0 0",
               align_fault, mem_req, stall);
    else passed++;
    tick();
    @(negedge clk);
    total++;
    if (align_fault !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL mis_pulse: got af%b req%b want 0 0",
               align_fault, mem_req);
    else passed++;
  endtask

  task automatic test_timeout();
    int req_cyc = 0;
    tick();
    drive_op(1'b1, 1'b0, 64'h3000, 9'h000, 64'h0, 5'd2);
    tick();
    clear_op();
    @(negedge clk);
    for (int i = 0; i < 40 && mem_req; i++) begin
      req_cyc++;
      if (timeout_fault) req_cyc += 100;
      tick();
      @(negedge clk);
    end
    total++;
    if (req_cyc != 16)
      $display("FAIL to_req_len: got %0d want 16", req_cyc);
    else passed++;
    total++;
    if (timeout_fault !== 1'b1 || stall !== 1'b0 || ld_valid !== 1'b0)
      $display("FAIL to_fault: got tf%b st%b lv%b want 1 0 0",
               timeout_fault, stall, ld_valid);
    else passed++;
    tick();
    @(negedge clk);
    total++;
    if (timeout_fault !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL to_pulse: got tf%b req%b want 0 0",
               timeout_fault, mem_req);
    else passed++;
  endtask

  task automatic test_reset_busy();
    tick();
    drive_op(1'b1, 1'b0, 64'h5000, 9'h008, 64'h0, 5'd4);
    tick();
    clear_op();
    @(negedge clk);
    total++;
    if (mem_req !== 1'b1)
      $display("FAIL rb_busy: got %b want 1", mem_req);
    else passed++;
    tick();
    #1;
    reset = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b0 || stall !== 1'b0)
      $display("FAIL rb_async: got req%b st%b want 0 0",
               mem_req, stall);
    else passed++;
    @(negedge clk);
    total++;
    if (ld_valid !== 1'b0 || ld_data !== 64'h0)
      $display("FAIL rb_noload: got v%b %h want 0 0", ld_valid, ld_data);
    else passed++;
    tick();
    reset = 1'b0;
    drive_op(1'b1, 1'b0, 64'h6000, 9'h018, 64'h0, 5'd7);
    tick();
    clear_op();
    mem_ack   = 1'b1;
    mem_rdata = 64'h1234;
    @(negedge clk);
    total++;
    if (mem_addr !== 64'h6018 || mem_req !== 1'b1)
      $display("FAIL rb_re_addr: got %h req%b want 6018 1",
               mem_addr, mem_req);
    else passed++;
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    total++;
    if (ld_valid !== 1'b1 || ld_data !== 64'h1234 || ld_reg !== 5'd7)
      $display("FAIL rb_re_load: got v%b %h r%0d want v1 1234 r7",
               ld_valid, ld_data, ld_reg);
    else passed++;
  endtask

  task automatic test_back_to_back();
    tick();
    drive_op(1'b1, 1'b0, 64'h0, 9'h1F8, 64'h0, 5'd3);
    @(negedge clk);
    total++;
    if (stall !== 1'b1)
      $display("FAIL wrap_acc: got %b want 1", stall);
    else passed++;
    tick();
    clear_op();
    mem_ack   = 1'b1;
    mem_rdata = 64'hCAFE;
    @(negedge clk);
    total++;
    if (mem_addr !== 64'hFFFF_FFFF_FFFF_FFF8 || mem_req !== 1'b1)
      $display("FAIL wrap_addr: got %h req%b want fffffffffffffff8 1",
               mem_addr, mem_req);
    else passed++;
    tick();
    mem_ack = 1'b0;
    drive_op(1'b0, 1'b1, 64'h4000, 9'h008, 64'h77, 5'd0);
    @(negedge clk);
    total++;
    if (ld_valid !== 1'b1 || ld_data !== 64'hCAFE || ld_reg !== 5'd3
        || align_fault !== 1'b0)
      $display("FAIL wrap_done: got v%b %h r%0d af%b want v1 cafe r3 af0",
               ld_valid, ld_data, ld_reg, align_fault);
    else passed++;
    total++;
    if (stall !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL b2b_done: got st%b req%b want 0 0", stall, mem_req);
    else passed++;
    tick();
    @(negedge clk);
    total++;
    if (stall !== 1'b1 || mem_req !== 1'b0)
      $display("FAIL b2b_acc: got st%b req%b want 1 0", stall, mem_req);
    else passed++;
    tick();
    clear_op();
    mem_ack = 1'b1;
    @(negedge clk);
    total++;
    if (mem_addr !== 64'h4008 || mem_we !== 1'b1
        || mem_wdata !== 64'h77 || mem_req !== 1'b1)
      $display("FAIL b2b_busy: got %h we%b %h req%b want 4008 1 77 1",
               mem_addr, mem_we, mem_wdata, mem_req);
    else passed++;
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    total++;
    if (ld_valid !== 1'b0 || ld_data !== 64'hCAFE || mem_req !== 1'b0)
      $display("FAIL b2b_done2: got v%b %h req%b want 0 cafe 0",
               ld_valid, ld_data, mem_req);
    else passed++;
  endtask

  initial begin
    reset      = 1'b1;
    clear_op();
    base_addr  = '0;
    dAddr9     = '0;
    store_data = '0;
    dest_reg   = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    test_reset();
    test_aligned_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_reset_busy();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
